// File: rtl/gf180mcu_osu_sc_12t_clkdiv_prog.sv
// Programmable clock divider: registered divided clock Y, ratio and run/stop
// changes applied only at period boundaries so Y never produces a runt pulse.
//
// state | meaning
// IDLE  | stopped, Y parked low, phase counter held at 0
// RUN   | dividing, k counts 0..CURDIV-1 through each period
module gf180mcu_osu_sc_12t_clkdiv_prog #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  output logic             Y,
  output logic             TICK,
  output logic             ACTIVE,
  output logic [WIDTH-1:0] CURDIV
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] k_q, k_d;
  logic [WIDTH-1:0] curdiv_q, curdiv_d;
  logic             y_q, y_d;
  logic             tick_q, tick_d;

  logic [WIDTH-1:0] div_clamped;
  logic [WIDTH:0]   k_inc;
  logic [WIDTH:0]   high_len;
  logic             last_cycle;

  assign div_clamped = (DIV < WIDTH'(2)) ? WIDTH'(2) : DIV;
  assign k_inc       = {1'b0, k_q} + {{WIDTH{1'b0}}, 1'b1};
  // High phase is ceil(N/2); the extra bit keeps N+1 from overflowing.
  assign high_len    = ({1'b0, curdiv_q} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
  assign last_cycle  = (k_q == (curdiv_q - WIDTH'(1)));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      k_q      <= '0;
      curdiv_q <= WIDTH'(2);
      y_q      <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      curdiv_q <= curdiv_d;
      y_q      <= y_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    curdiv_d = curdiv_q;
    y_d      = y_q;
    tick_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        k_d = '0;
        y_d = 1'b0;
        if (EN) begin
          state_d  = RUN;
          curdiv_d = div_clamped;
          y_d      = 1'b1;
          tick_d   = 1'b1;
        end
      end
      RUN: begin
        if (!last_cycle) begin
          k_d = k_inc[WIDTH-1:0];
          y_d = (k_inc < high_len);
        end else if (EN) begin
          k_d      = '0;
          curdiv_d = div_clamped;
          y_d      = 1'b1;
          tick_d   = 1'b1;
        end else begin
          state_d = IDLE;
          k_d     = '0;
          y_d     = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
        y_d     = 1'b0;
      end
    endcase
  end

  always_comb begin
    Y      = y_q;
    TICK   = tick_q;
    ACTIVE = (state_q == RUN);
    CURDIV = curdiv_q;
  end

endmodule
